// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_pkg
// Brief    : Shared state encoding and BCD constants for the countdown timer.
// Revision : 1.0
// ============================================================================
package countdown_pkg;

    localparam int c_bcd_w   = 4;
    localparam int c_bcd_max = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/countdown_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl_if
// Brief    : Keypad event inputs and BCD display outputs of the countdown timer.
// Revision : 1.0
// ============================================================================
interface countdown_ctrl_if
    import countdown_pkg::*;
#(
    parameter int DIGITS = 2
);
    logic                        key_start;
    logic                        key_confirm;
    logic                        key_clear;
    logic                        key_pause;
    logic                        key_num;
    logic [3:0]                  num;
    logic [c_bcd_w*DIGITS-1:0]   setting;
    logic [c_bcd_w*DIGITS-1:0]   remaining;
    logic                        display_en;
    logic                        running;
    logic                        expired;
    logic [2:0]                  state;

    modport master (
        output key_start, key_confirm, key_clear, key_pause, key_num, num,
        input  setting, remaining, display_en, running, expired, state
    );

    modport slave (
        input  key_start, key_confirm, key_clear, key_pause, key_num, num,
        output setting, remaining, display_en, running, expired, state
    );

endinterface
`default_nettype wire

// File: rtl/countdown_ctrl_bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter
// Brief    : Multi-digit BCD register with parallel load and borrow decrement.
// Revision : 1.0
// ============================================================================
module bcd_down_counter
    import countdown_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [c_bcd_w*DIGITS-1:0] load_val_i,
    input  logic                      dec_i,
    output logic [c_bcd_w*DIGITS-1:0] count_o,
    output logic                      zero_next_o
);

    localparam int c_w = c_bcd_w * DIGITS;
    localparam logic [c_w-1:0] c_one = c_w'(1);

    logic [c_w-1:0] count_q;
    logic [c_w-1:0] count_d;
    logic [c_w-1:0] w_dec_val;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            logic [c_bcd_w-1:0] w_digit;
            logic               w_borrow_in;

            assign w_digit = count_q[i*c_bcd_w +: c_bcd_w];

            // A digit borrows exactly when every less significant digit is zero.
            if (i == 0) begin : g_lsd
                assign w_borrow_in = 1'b1;
            end else begin : g_upper
                assign w_borrow_in = (count_q[i*c_bcd_w-1:0] == '0);
            end

            assign w_dec_val[i*c_bcd_w +: c_bcd_w] =
                !w_borrow_in       ? w_digit :
                (w_digit == '0)    ? c_bcd_w'(c_bcd_max) :
                                     w_digit - 1'b1;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = w_dec_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign zero_next_o = dec_i && (count_q == c_one);

endmodule
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl
// Brief    : Keypad-driven BCD countdown timer with prescaler, pause and reload.
// Revision : 1.0
// ============================================================================
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 100_000_000,
    parameter int RELOAD   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    countdown_ctrl_if.slave bus_io
);

    localparam int c_w  = c_bcd_w * DIGITS;
    localparam int c_pw = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);

    state_e          state_q, state_d;
    logic [c_w-1:0]  setting_q, setting_d;
    logic [c_pw-1:0] presc_q, presc_d;
    logic            expired_q, expired_d;

    logic            w_cnt_load;
    logic [c_w-1:0]  w_cnt_load_val;
    logic            w_cnt_dec;
    logic            w_zero_next;
    logic [c_w-1:0]  w_remaining;
    logic            w_tick;

    logic            w_k_start, w_k_clear, w_k_confirm, w_k_pause, w_k_num;

    // Only the highest-priority key of a simultaneous group is allowed to act.
    assign w_k_start   = bus_io.key_start;
    assign w_k_clear   = bus_io.key_clear   && !w_k_start;
    assign w_k_confirm = bus_io.key_confirm && !w_k_start && !bus_io.key_clear;
    assign w_k_pause   = bus_io.key_pause   && !w_k_start && !bus_io.key_clear
                                            && !bus_io.key_confirm;
    assign w_k_num     = bus_io.key_num     && !w_k_start && !bus_io.key_clear
                                            && !bus_io.key_confirm && !bus_io.key_pause;

    assign w_tick = (state_q == ST_RUN) && (presc_q == c_presc_max);

    bcd_down_counter #(
        .DIGITS (DIGITS)
    ) u_remaining (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_cnt_load),
        .load_val_i  (w_cnt_load_val),
        .dec_i       (w_cnt_dec),
        .count_o     (w_remaining),
        .zero_next_o (w_zero_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            setting_q <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            setting_q <= setting_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        setting_d      = setting_q;
        presc_d        = presc_q;
        expired_d      = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;

        if (w_k_start) begin
            state_d    = ST_ENTRY;
            setting_d  = '0;
            presc_d    = '0;
            w_cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (w_k_clear) begin
                        setting_d = '0;
                    end else if (w_k_confirm && (setting_q != '0)) begin
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = setting_q;
                        presc_d        = '0;
                        state_d        = ST_RUN;
                    end else if (w_k_num && (bus_io.num <= 4'(c_bcd_max))) begin
                        setting_d = (setting_q << c_bcd_w) | c_w'(bus_io.num);
                    end
                end
                ST_RUN: begin
                    if (w_k_clear) begin
                        w_cnt_load = 1'b1;
                        state_d    = ST_ENTRY;
                    end else begin
                        if (w_tick) begin
                            presc_d   = '0;
                            w_cnt_dec = 1'b1;
                            if (w_zero_next) begin
                                expired_d = 1'b1;
                                if (RELOAD != 0) begin
                                    w_cnt_load     = 1'b1;
                                    w_cnt_load_val = setting_q;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                        // A pause coinciding with the tick lets the tick land first.
                        if (w_k_pause && (state_d == ST_RUN)) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_k_clear) begin
                        w_cnt_load = 1'b1;
                        state_d    = ST_ENTRY;
                    end else if (w_k_confirm) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus_io.state      = 3'(state_q);
        bus_io.setting    = setting_q;
        bus_io.remaining  = w_remaining;
        bus_io.expired    = expired_q;
        bus_io.display_en = (state_q != ST_IDLE);
        bus_io.running    = (state_q == ST_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_ctrl
// Brief    : Directed and random checks of two timers (RELOAD=0 and RELOAD=1).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_countdown_ctrl;
    import countdown_pkg::*;

    localparam int TB_TICK = 4;
    localparam int TB_MOD  = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic k_start = 1'b0, k_clear = 1'b0, k_confirm = 1'b0, k_pause = 1'b0, k_num = 1'b0;
    logic [3:0] k_num_v = 4'd0;

    int checks = 0;
    int errors = 0;

    state_e m_mode [2];
    int     m_set  [2];
    int     m_rem  [2];
    int     m_phase[2];
    bit     m_exp  [2];

    always #5 clk = ~clk;

    countdown_ctrl_if #(.DIGITS(2)) ifa ();
    countdown_ctrl_if #(.DIGITS(2)) ifb ();

    assign ifa.key_start = k_start;   assign ifb.key_start = k_start;
    assign ifa.key_clear = k_clear;   assign ifb.key_clear = k_clear;
    assign ifa.key_confirm = k_confirm; assign ifb.key_confirm = k_confirm;
    assign ifa.key_pause = k_pause;   assign ifb.key_pause = k_pause;
    assign ifa.key_num = k_num;       assign ifb.key_num = k_num;
    assign ifa.num = k_num_v;         assign ifb.num = k_num_v;

    countdown_ctrl #(.DIGITS(2), .TICK_DIV(TB_TICK), .RELOAD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus_io(ifa)
    );
    countdown_ctrl #(.DIGITS(2), .TICK_DIV(TB_TICK), .RELOAD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus_io(ifb)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = ST_IDLE; m_set[d] = 0; m_rem[d] = 0; m_phase[d] = 0; m_exp[d] = 1'b0;
        end
    endfunction

    // Decimal-valued timer: one call per clock edge with the keys seen at that edge.
    function automatic void model_step(input int d, input bit reload);
        int hk;
        hk = k_start ? 1 : k_clear ? 2 : k_confirm ? 3 : k_pause ? 4 : k_num ? 5 : 0;
        m_exp[d] = 1'b0;
        if (hk == 1) begin
            m_mode[d] = ST_ENTRY; m_set[d] = 0; m_rem[d] = 0; m_phase[d] = 0;
        end else begin
            case (m_mode[d])
                ST_ENTRY: begin
                    if (hk == 2) m_set[d] = 0;
                    else if (hk == 3 && m_set[d] != 0) begin
                        m_rem[d] = m_set[d]; m_phase[d] = 0; m_mode[d] = ST_RUN;
                    end else if (hk == 5 && int'(k_num_v) <= 9)
                        m_set[d] = (m_set[d] * 10 + int'(k_num_v)) % TB_MOD;
                end
                ST_RUN: begin
                    if (hk == 2) begin
                        m_mode[d] = ST_ENTRY; m_rem[d] = 0;
                    end else begin
                        m_phase[d]++;
                        if (m_phase[d] == TB_TICK) begin
                            m_phase[d] = 0;
                            m_rem[d]--;
                            if (m_rem[d] == 0) begin
                                m_exp[d] = 1'b1;
                                if (reload) m_rem[d] = m_set[d];
                                else m_mode[d] = ST_DONE;
                            end
                        end
                        if (hk == 4 && m_mode[d] == ST_RUN) m_mode[d] = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (hk == 2) begin
                        m_mode[d] = ST_ENTRY; m_rem[d] = 0;
                    end else if (hk == 3) m_mode[d] = ST_RUN;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic step(input logic s, input logic cl, input logic cf, input logic p,
                        input logic n, input logic [3:0] v);
        k_start = s; k_clear = cl; k_confirm = cf; k_pause = p; k_num = n; k_num_v = v;
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        k_start = 0; k_clear = 0; k_confirm = 0; k_pause = 0; k_num = 0; k_num_v = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifa.state !== 3'(ST_IDLE)) begin errors++; $display("FAIL reset_state: got %0d exp %0d", ifa.state, ST_IDLE); end
        checks++;
        if (ifa.setting !== 8'h00 || ifa.remaining !== 8'h00) begin
            errors++; $display("FAIL reset_values: setting %h remaining %h exp 00 00", ifa.setting, ifa.remaining);
        end
        checks++;
        if ({ifa.display_en, ifa.running, ifa.expired} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b exp 000", {ifa.display_en, ifa.running, ifa.expired});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_entry();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd1);
        step(0, 0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 0, 1, 4'd5);
        checks++;
        if (ifa.setting !== 8'h25) begin errors++; $display("FAIL entry_setting: got %h exp 25", ifa.setting); end
        checks++;
        if (ifa.display_en !== 1'b1 || ifa.state !== 3'(ST_ENTRY)) begin
            errors++; $display("FAIL entry_state: display_en %b state %0d exp 1 %0d", ifa.display_en, ifa.state, ST_ENTRY);
        end
    endtask

    task automatic test_ignored();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 4'd7);
        checks++;
        if (ifa.setting !== 8'h00 || ifa.state !== 3'(ST_ENTRY)) begin
            errors++; $display("FAIL ignore_start_num: setting %h state %0d exp 00 %0d", ifa.setting, ifa.state, ST_ENTRY);
        end
        step(0, 0, 0, 0, 1, 4'hA);
        checks++;
        if (ifa.setting !== 8'h00) begin errors++; $display("FAIL ignore_num_a: got %h exp 00", ifa.setting); end
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (ifa.state !== 3'(ST_ENTRY) || ifa.running !== 1'b0) begin
            errors++; $display("FAIL ignore_confirm_zero: state %0d running %b exp %0d 0", ifa.state, ifa.running, ST_ENTRY);
        end
    endtask

    task automatic test_countdown();
        logic [7:0] ea, eb;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd3);
        step(0, 0, 1, 0, 0, 0);
        for (int e = 1; e <= 13; e++) begin
            step(0, 0, 0, 0, 0, 0);
            ea = (e < 12) ? 8'(3 - e / 4) : 8'h00;
            eb = 8'(3 - ((e / 4) % 3));
            checks++;
            if (ifa.remaining !== ea || ifa.expired !== (e == 12)) begin
                errors++; $display("FAIL countdown_a e=%0d: remaining %h expired %b exp %h %b", e, ifa.remaining, ifa.expired, ea, (e == 12));
            end
            checks++;
            if (ifb.remaining !== eb || ifb.expired !== (e == 12) || ifb.state !== 3'(ST_RUN)) begin
                errors++; $display("FAIL countdown_b e=%0d: remaining %h expired %b state %0d exp %h %b %0d", e, ifb.remaining, ifb.expired, ifb.state, eb, (e == 12), ST_RUN);
            end
        end
        checks++;
        if (ifa.state !== 3'(ST_DONE) || ifa.running !== 1'b0) begin
            errors++; $display("FAIL countdown_done: state %0d running %b exp %0d 0", ifa.state, ifa.running, ST_DONE);
        end
    endtask

    task automatic test_pause();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd1);
        step(0, 0, 0, 0, 1, 4'd0);
        step(0, 0, 1, 0, 0, 0);
        for (int e = 1; e <= 5; e++) begin
            step(0, 0, 0, 0, 0, 0);
            if (e == 4) begin
                checks++;
                if (ifa.remaining !== 8'h09) begin errors++; $display("FAIL pause_borrow: got %h exp 09", ifa.remaining); end
            end
        end
        step(0, 0, 0, 1, 0, 0);
        for (int e = 0; e < 20; e++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (ifa.remaining !== 8'h09 || ifa.state !== 3'(ST_PAUSE)) begin
                errors++; $display("FAIL pause_hold c=%0d: remaining %h state %0d exp 09 %0d", e, ifa.remaining, ifa.state, ST_PAUSE);
            end
        end
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (ifa.remaining !== 8'h09 || ifa.running !== 1'b1) begin
            errors++; $display("FAIL pause_resume1: remaining %h running %b exp 09 1", ifa.remaining, ifa.running);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (ifa.remaining !== 8'h08) begin errors++; $display("FAIL pause_resume2: got %h exp 08", ifa.remaining); end
    endtask

    task automatic test_reload();
        logic [7:0] ea, eb;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd2);
        step(0, 0, 1, 0, 0, 0);
        for (int e = 1; e <= 25; e++) begin
            step(0, 0, 0, 0, 0, 0);
            eb = 8'(2 - ((e / 4) % 2));
            ea = (e < 8) ? 8'(2 - e / 4) : 8'h00;
            checks++;
            if (ifb.expired !== (e % 8 == 0) || ifb.remaining !== eb || ifb.state !== 3'(ST_RUN)) begin
                errors++; $display("FAIL reload_b e=%0d: expired %b remaining %h state %0d exp %b %h %0d", e, ifb.expired, ifb.remaining, ifb.state, (e % 8 == 0), eb, ST_RUN);
            end
            checks++;
            if (ifa.expired !== (e == 8) || ifa.remaining !== ea) begin
                errors++; $display("FAIL reload_a e=%0d: expired %b remaining %h exp %b %h", e, ifa.expired, ifa.remaining, (e == 8), ea);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd5);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (ifa.remaining !== 8'h05 || ifa.running !== 1'b1) begin
            errors++; $display("FAIL arst_pre: remaining %h running %b exp 05 1", ifa.remaining, ifa.running);
        end
        #2 rst_n = 1'b0;
        #0.5;
        checks++;
        if ({ifa.state, ifa.setting, ifa.remaining, ifa.display_en, ifa.running, ifa.expired} !== 22'd0 ||
            {ifb.state, ifb.setting, ifb.remaining, ifb.display_en, ifb.running, ifb.expired} !== 22'd0) begin
            errors++; $display("FAIL arst_clear: a state %0d rem %h b state %0d rem %h exp all zero", ifa.state, ifa.remaining, ifb.state, ifb.remaining);
        end
        #0.5 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [21:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) < 8, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25, 4'($urandom_range(0, 11)));
            got = {ifa.state, ifa.setting, ifa.remaining, ifa.display_en, ifa.running, ifa.expired};
            exp = {3'(m_mode[0]), to_bcd(m_set[0]), to_bcd(m_rem[0]), m_mode[0] != ST_IDLE, m_mode[0] == ST_RUN, m_exp[0]};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_a cyc=%0d: got %h exp %h", i, got, exp);
            end
            got = {ifb.state, ifb.setting, ifb.remaining, ifb.display_en, ifb.running, ifb.expired};
            exp = {3'(m_mode[1]), to_bcd(m_set[1]), to_bcd(m_rem[1]), m_mode[1] != ST_IDLE, m_mode[1] == ST_RUN, m_exp[1]};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_b cyc=%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_entry();
        test_ignored();
        test_countdown();
        test_pause();
        test_reload();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
